uart_frame_parse: RTL

UART_FRAME_PARSE -- requirements
Module: uart_frame_parse

---
 rtl/uart_frame_pkg.sv | 38 +++
 rtl/uart_frame_parse_byte_timeout_cnt.sv | 36 +++
 rtl/uart_frame_parse.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART command-frame parser.
// Frame on the wire: HDR, OP, ADDR[23:16], ADDR[15:8], ADDR[7:0], DATA, CHK.
package uart_frame_pkg;

  localparam logic [7:0] HDR_DEFAULT   = 8'hAA;
  localparam logic [7:0] OP_BYTE_WRITE = 8'h01;
  localparam logic [7:0] OP_BYTE_ERASE = 8'h02;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_ERASE = 2'b10
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_OVERRUN  = 2'b00,
    ERR_CHECKSUM = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_BAD_OP   = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_A2,
    ST_A1,
    ST_A0,
    ST_DAT,
    ST_CHK,
    ST_OUT
  } state_e;

  // True while a frame is partially received and the inter-byte timer is live.
  function automatic logic in_frame(input state_e s);
    return (s != ST_IDLE) && (s != ST_OUT);
  endfunction

endpackage

// File: rtl/uart_frame_parse_byte_timeout_cnt.sv
// Inter-byte timer: cleared by each byte, held at zero when disabled,
// saturates at LIMIT-1 and pulses expire for exactly one cycle on reaching it.
module byte_timeout_cnt #(
  parameter  int unsigned LIMIT = 500000,
  localparam int unsigned W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic sclk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;
  logic         fired;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      count <= '0;
      fired <= 1'b0;
    end else if (!en || clr) begin
      count <= '0;
      fired <= 1'b0;
    end else begin
      if (count != LAST) count <= count + 1'b1;
      if (count == LAST) fired <= 1'b1;
    end
  end

  // A byte arriving in the expiry cycle wins, hence the clr gate.
  assign expire = en && !clr && (count == LAST) && !fired;

endmodule

// File: rtl/uart_frame_parse.sv
// Parses HDR/OP/ADDR/DATA/CHK byte frames from a UART receiver into
// write/erase commands with a valid/ready handshake and error strobes.
module uart_frame_parse
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR         = HDR_DEFAULT
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [7:0]  po_data,
  input  logic        po_flag,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        err_flag,
  output logic [1:0]  err_code
);

  state_e    state_q, state_d;
  cmd_op_e   op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  xor_q, xor_d;
  logic        err_q, err_d;
  err_code_e   code_q, code_d;
  logic        expire;

  byte_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .sclk   (sclk),
    .rst    (rst),
    .en     (in_frame(state_q)),
    .clr    (po_flag),
    .expire (expire)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= CMD_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      xor_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_OVERRUN;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      xor_q   <= xor_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    xor_d   = xor_q;
    err_d   = 1'b0;
    code_d  = code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (po_flag && (po_data == HDR)) begin
          state_d = ST_OP;
          xor_d   = '0;
        end
      end
      ST_OP: begin
        if (po_flag) begin
          if ((po_data == OP_BYTE_WRITE) || (po_data == OP_BYTE_ERASE)) begin
            op_d    = (po_data == OP_BYTE_WRITE) ? CMD_WRITE : CMD_ERASE;
            xor_d   = xor_q ^ po_data;
            state_d = ST_A2;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_BAD_OP;
          end
        end
      end
      ST_A2: begin
        if (po_flag) begin
          addr_d[23:16] = po_data;
          xor_d         = xor_q ^ po_data;
          state_d       = ST_A1;
        end
      end
      ST_A1: begin
        if (po_flag) begin
          addr_d[15:8] = po_data;
          xor_d        = xor_q ^ po_data;
          state_d      = ST_A0;
        end
      end
      ST_A0: begin
        if (po_flag) begin
          addr_d[7:0] = po_data;
          xor_d       = xor_q ^ po_data;
          state_d     = ST_DAT;
        end
      end
      ST_DAT: begin
        if (po_flag) begin
          data_d  = po_data;
          xor_d   = xor_q ^ po_data;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (po_flag) begin
          if (po_data == xor_q) begin
            state_d = ST_OUT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
          end
        end
      end
      ST_OUT: begin
        // A byte here has nowhere to go; it is dropped even on the transfer cycle.
        if (po_flag) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // expire is only ever high in a frame state without a byte, so no other error competes.
    if (expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  assign cmd_valid = (state_q == ST_OUT);
  assign cmd_op    = op_q;
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign err_flag  = err_q;
  assign err_code  = code_q;

endmodule
